// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared widths, reset fetch address and FSM state encoding
// for the instruction fetch unit.
package ifu_fetch_pkg;

  localparam int          IFU_PC_WIDTH    = 32;
  localparam int          IFU_INSTR_WIDTH = 32;
  localparam logic [31:0] IFU_RESET_PC    = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit feeding the write side of the IF/ID
// register. Owns the fetch PC, runs a single-outstanding valid/ready request
// to instruction memory, holds the fetched word until IF/ID captures it and
// squashes in-flight work on a branch-predictor redirect.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   imem_req_valid/ready/addr         fetch request handshake
//   imem_resp_valid/data              instruction response
//   if_id_reg_enable                  IF/ID captures this cycle
//   redirect_valid/pc                 BPU redirect (also clears IF/ID)
//   fetch_valid, PC, Instr, PC_4      IF/ID write data, zeroed when not valid
//
// state | meaning
// ------+---------------------------------------------------------------
// BOOT  | reset state, leaves to REQ on the first edge after reset release
// REQ   | request pc on imem, waiting for ready
// WAIT  | request accepted, waiting for its response
// HOLD  | instruction held for IF/ID, advance pc on enable
// DRAIN | squashed request outstanding, discard its response
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int                    PC_WIDTH    = IFU_PC_WIDTH,
  parameter int                    INSTR_WIDTH = IFU_INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = PC_WIDTH'(IFU_RESET_PC)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [PC_WIDTH-1:0]    imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_resp_data,
  input  logic                   if_id_reg_enable,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   fetch_valid,
  output logic [PC_WIDTH-1:0]    PC,
  output logic [INSTR_WIDTH-1:0] Instr,
  output logic [PC_WIDTH-1:0]    PC_4
);

  fetch_state_e           r_state;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [INSTR_WIDTH-1:0] r_instr;

  fetch_state_e           w_state_d;
  logic                   w_pc_load;
  logic [PC_WIDTH-1:0]    w_pc_d;
  logic                   w_instr_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_BOOT;
    else        r_state <= w_state_d;
  end

  always_comb begin
    w_state_d    = r_state;
    w_pc_load    = 1'b0;
    w_pc_d       = r_pc;
    w_instr_load = 1'b0;

    case (r_state)
      ST_BOOT: w_state_d = ST_REQ;

      ST_REQ: begin
        if (redirect_valid) begin
          w_pc_load = 1'b1;
          w_pc_d    = redirect_pc;
          // an accepted request still carries the old address and must be drained
          w_state_d = imem_req_ready ? ST_DRAIN : ST_REQ;
        end else if (imem_req_ready) begin
          w_state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (redirect_valid) begin
          w_pc_load = 1'b1;
          w_pc_d    = redirect_pc;
          w_state_d = imem_resp_valid ? ST_REQ : ST_DRAIN;
        end else if (imem_resp_valid) begin
          w_instr_load = 1'b1;
          w_state_d    = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (redirect_valid) begin
          w_pc_load = 1'b1;
          w_pc_d    = redirect_pc;
          w_state_d = ST_REQ;
        end else if (if_id_reg_enable) begin
          w_pc_load = 1'b1;
          w_pc_d    = r_pc + PC_WIDTH'(4);
          w_state_d = ST_REQ;
        end
      end

      ST_DRAIN: begin
        if (redirect_valid) begin
          w_pc_load = 1'b1;
          w_pc_d    = redirect_pc;
        end
        if (imem_resp_valid) w_state_d = ST_REQ;
      end

      default: w_state_d = ST_BOOT;
    endcase

    imem_req_valid = (r_state == ST_REQ);
    imem_req_addr  = r_pc;
    fetch_valid    = (r_state == ST_HOLD);
    PC             = fetch_valid ? r_pc : '0;
    Instr          = fetch_valid ? r_instr : '0;
    PC_4           = fetch_valid ? (r_pc + PC_WIDTH'(4)) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else begin
      if (w_pc_load)    r_pc    <= w_pc_d;
      if (w_instr_load) r_instr <= imem_resp_data;
    end
  end

endmodule
